// File: rtl/uart_tx.sv
// FIFO-fed UART transmitter with an internal 16x-oversampling baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_empty,
  input  logic [DBIT-1:0] tx_data,
  output logic            tx_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_reg, state_next;
  logic [DVSR_W-1:0] b_reg, b_next;
  logic [S_W-1:0]    s_reg, s_next;
  logic [N_W-1:0]    n_reg, n_next;
  logic [DBIT-1:0]   sh_reg, sh_next;
  logic              tx_reg, tx_next;
  logic              tick;
`ifdef UART_TX_PARITY_EN
  logic              par_reg, par_next;
`endif

  assign tick = (b_reg == DVSR_W'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      sh_reg    <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      sh_reg    <= sh_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    b_next       = '0;
    s_next       = s_reg;
    n_next       = n_reg;
    sh_next      = sh_reg;
    tx_rd        = 1'b0;
    tx_done_tick = 1'b0;
    tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_next     = par_reg;
`endif
    // Baud divisor only runs while a frame is in flight.
    if (state_reg != IDLE)
      b_next = tick ? '0 : b_reg + 1'b1;

    case (state_reg)
      IDLE:
        if (!tx_empty && !reset) begin
          tx_rd      = 1'b1;
          sh_next    = tx_data;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          par_next   = ^tx_data;
`endif
        end
      START:
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next     = '0;
            state_next = DATA;
          end else
            s_next = s_reg + 1'b1;
        end
      DATA:
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next  = '0;
            sh_next = sh_reg >> 1;
            if (n_reg == N_W'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            else
              n_next = n_reg + 1'b1;
          end else
            s_next = s_reg + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next     = '0;
            state_next = STOP;
          end else
            s_next = s_reg + 1'b1;
        end
`endif
      STOP:
        if (tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else
            s_next = s_reg + 1'b1;
        end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered, so tx changes exactly on bit edges.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = sh_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model feeding two configurations; a scoreboard of pushed
// bytes is checked against a frame-level model of the serial line.
module tb_uart_tx;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DV_A = 2, SB_A = 16, DV_B = 1, SB_B = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         tx_empty = 2'b11;
  logic [1:0][DB-1:0] tx_data = '0;
  logic [1:0]         tx_rd, tx, tx_busy, tx_done;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(DB), .SB_TICK(SB_A), .DVSR(DV_A), .DVSR_W(8)) dut_a (
    .clk(clk), .reset(reset), .tx_empty(tx_empty[0]), .tx_data(tx_data[0]),
    .tx_rd(tx_rd[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done_tick(tx_done[0]));

  uart_tx #(.DBIT(DB), .SB_TICK(SB_B), .DVSR(DV_B), .DVSR_W(4)) dut_b (
    .clk(clk), .reset(reset), .tx_empty(tx_empty[1]), .tx_data(tx_data[1]),
    .tx_rd(tx_rd[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done_tick(tx_done[1]));

  logic [DB-1:0] fq0[$], fq1[$], eq0[$], eq1[$];
  int   vec = 0, mis = 0, to_cnt = 0, cyc = 0;
  logic stim_done = 1'b0;

  // FIFO model: head is combinational read data, pop after the loading edge.
  logic [1:0] rd_s;
  always begin
    @(negedge clk);
    rd_s = tx_rd;
    @(posedge clk);
    #1;
    if (rd_s[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (rd_s[1] && fq1.size() > 0) void'(fq1.pop_front());
    tx_empty[0] = (fq0.size() == 0);
    tx_empty[1] = (fq1.size() == 0);
    tx_data[0]  = (fq0.size() > 0) ? fq0[0] : DB'($urandom);
    tx_data[1]  = (fq1.size() > 0) ? fq1[0] : DB'($urandom);
  end

  task automatic push(input logic [DB-1:0] b);
    fq0.push_back(b); eq0.push_back(b);
    fq1.push_back(b); eq1.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      @(negedge clk);
      if (fq0.size() == 0 && fq1.size() == 0 && tx_busy == 2'b00) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
      to_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    push(8'h48);
    wait_idle(2000);
    push(8'h48); push(8'h45); push(8'h0A); push(8'h0D);
    wait_idle(4000);
    push(8'h07); push(8'h03);
    wait_idle(2000);
    // abandon a frame with a reset during data bit 3 of the slower config
    push(8'hA5); push(8'h3C);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_rd[0]) found = 1'b1;
    end
    if (!found) begin
      $display("FAIL mid_reset_pop: no tx_rd within 50 cycles, required one");
      to_cnt++;
    end
    repeat (140) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle(2000);
    repeat (16) begin
      push(DB'($urandom));
      repeat ($urandom_range(1, 400)) @(posedge clk);
      #1;
    end
    wait_idle(20000);
    stim_done = 1'b1;
  end

  // Reference line: frame bit index -> level, each bit 16*DVSR cycles, stop SB_TICK*DVSR.
  function automatic logic bit_of(input logic [DB-1:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return b[idx-1];
    if (PAR == 1 && idx == DB + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int d, input logic ok, input int act, input int req);
    vec++;
    if (!ok) begin
      mis++;
      $display("FAIL %s dut%0d: got 'h%0h, required 'h%0h", nm, d, act, req);
    end
  endtask

  int            k[2], ferr[2], ierr[2];
  logic [DB-1:0] cur[2], dec[2];
  int            m_dv, m_bt, m_len, m_idx;
  logic          m_eb, m_erd, m_have;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_dv  = (d == 0) ? DV_A : DV_B;
      m_bt  = 16 * m_dv;
      m_len = m_dv * (16 * (1 + DB + PAR) + ((d == 0) ? SB_A : SB_B));
      if (k[d] > 0) begin
        if (reset) k[d] = 0;
        else begin
          m_idx = (k[d] - 1) / m_bt;
          m_eb  = bit_of(cur[d], m_idx);
          if (tx[d] !== m_eb || tx_busy[d] !== 1'b1 || tx_rd[d] !== 1'b0 ||
              tx_done[d] !== (k[d] == m_len))
            ferr[d]++;
          if ((k[d] - 1) % m_bt == m_bt / 2 && m_idx >= 1 && m_idx <= DB)
            dec[d][m_idx-1] = tx[d];
          if (k[d] == m_len) begin
            chk("frame_wave_bad_cycles", d, ferr[d] == 0, ferr[d], 0);
            chk("frame_byte", d, dec[d] == cur[d], int'(dec[d]), int'(cur[d]));
            k[d] = 0;
          end else k[d]++;
        end
      end else begin
        m_erd = !reset && !tx_empty[d];
        if (tx[d] !== 1'b1 || tx_busy[d] !== 1'b0 || tx_done[d] !== 1'b0 || tx_rd[d] !== m_erd)
          ierr[d]++;
        if (cyc == 1000) chk("reset_idle_bad_cycles", d, ierr[d] == 0, ierr[d], 0);
        if (tx_rd[d] === 1'b1 && !reset) begin
          chk("idle_bad_cycles", d, ierr[d] == 0, ierr[d], 0);
          ierr[d] = 0;
          m_have = (d == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
          chk("pop_expected", d, m_have, int'(m_have), 1);
          if (m_have) begin
            if (d == 0) cur[d] = eq0.pop_front();
            else cur[d] = eq1.pop_front();
            k[d] = 1; ferr[d] = 0; dec[d] = '0;
          end
        end
      end
    end
    if (stim_done || cyc > 90000) begin
      if (cyc > 90000) chk("watchdog", 0, 1'b0, cyc, 90000);
      chk("idle_final_bad_cycles", 0, ierr[0] == 0, ierr[0], 0);
      chk("idle_final_bad_cycles", 1, ierr[1] == 0, ierr[1], 0);
      chk("scoreboard_left", 0, eq0.size() == 0, eq0.size(), 0);
      chk("scoreboard_left", 1, eq1.size() == 0, eq1.size(), 0);
      chk("stim_timeouts", 0, to_cnt == 0, to_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
    end
  end

endmodule
